// File: rtl/decode_issue_fifo.sv
// Registered decode->issue FIFO with single-outstanding control-flow gating.
// The package carries the decoded instruction record shared with decode and issue.
package decode_issue_fifo_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  op;
    logic [4:0]  rd;
  } scoreboard_entry_t;
endpackage

module decode_issue_fifo
  import decode_issue_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  scoreboard_entry_t            decoded_instr_i,
  input  logic                         decoded_instr_valid_i,
  input  logic                         is_ctrl_flow_i,
  output logic                         decoded_instr_ack_o,
  output scoreboard_entry_t            issue_instr_o,
  output logic                         issue_instr_valid_o,
  output logic                         issue_is_ctrl_flow_o,
  input  logic                         issue_instr_ack_i,
  input  logic                         resolve_branch_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         stall_ctrl_flow_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic {
    BR_IDLE,
    BR_PENDING
  } br_state_t;

  scoreboard_entry_t mem [DEPTH];
  logic [DEPTH-1:0]  ctrl_q;
  logic [PW-1:0]     rd_q;
  logic [PW-1:0]     wr_q;
  logic [CW-1:0]     count_q;
  br_state_t         br_q;
  br_state_t         br_d;

  logic push;
  logic pop;
  logic head_ctrl;

  assign full_o              = (count_q == CW'(DEPTH));
  assign decoded_instr_ack_o = !full_o && !flush_i && !rst_i;
  assign push                = decoded_instr_valid_i && decoded_instr_ack_o;

  assign head_ctrl            = ctrl_q[rd_q];
  assign issue_instr_o        = mem[rd_q];
  assign issue_is_ctrl_flow_o = head_ctrl;
  assign issue_instr_valid_o  = (count_q != '0) && (br_q == BR_IDLE);
  assign pop                  = issue_instr_valid_o && issue_instr_ack_i;
  assign stall_ctrl_flow_o    = (count_q != '0) && (br_q == BR_PENDING);
  assign count_o              = count_q;

  // Payload is never cleared; only the ctrl bits reset so the head ctrl output is 0 out of reset.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_q] <= decoded_instr_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)     ctrl_q       <= '0;
    else if (push) ctrl_q[wr_q] <= is_ctrl_flow_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // A ctrl-flow pop takes priority over a same-cycle resolve.
  always_comb begin
    br_d = br_q;
    if (pop && head_ctrl)      br_d = BR_PENDING;
    else if (resolve_branch_i) br_d = BR_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) br_q <= BR_IDLE;
    else                  br_q <= br_d;
  end

endmodule

// File: tb/tb_decode_issue_fifo.sv
// Self-checking bench for decode_issue_fifo: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_decode_issue_fifo;
  import decode_issue_fifo_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  scoreboard_entry_t decoded_instr;
  logic              decoded_instr_valid;
  logic              is_ctrl_flow;
  logic              decoded_instr_ack;
  scoreboard_entry_t issue_instr;
  logic              issue_instr_valid;
  logic              issue_is_ctrl_flow;
  logic              issue_instr_ack;
  logic              resolve_branch;
  logic [CW-1:0]     count;
  logic              full;
  logic              stall_ctrl_flow;

  always #5 clk = ~clk;

  decode_issue_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .flush_i               (flush),
    .decoded_instr_i       (decoded_instr),
    .decoded_instr_valid_i (decoded_instr_valid),
    .is_ctrl_flow_i        (is_ctrl_flow),
    .decoded_instr_ack_o   (decoded_instr_ack),
    .issue_instr_o         (issue_instr),
    .issue_instr_valid_o   (issue_instr_valid),
    .issue_is_ctrl_flow_o  (issue_is_ctrl_flow),
    .issue_instr_ack_i     (issue_instr_ack),
    .resolve_branch_i      (resolve_branch),
    .count_o               (count),
    .full_o                (full),
    .stall_ctrl_flow_o     (stall_ctrl_flow)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: an ordered queue of entries plus one pending-branch flag.
  typedef struct {
    scoreboard_entry_t p;
    logic              c;
  } ment_t;

  ment_t mq[$];
  bit    mpend = 1'b0;
  bit    m_valid;
  bit    m_pop;
  bit    m_push;
  ment_t m_e;

  always @(negedge clk) begin
    m_valid = (mq.size() != 0) && !mpend;
    chk("ack",   decoded_instr_ack, 64'(mq.size() < DEPTH && !flush && !rst));
    chk("valid", issue_instr_valid, 64'(m_valid));
    chk("count", count,             64'(mq.size()));
    chk("full",  full,              64'(mq.size() == DEPTH));
    chk("stall", stall_ctrl_flow,   64'(mq.size() != 0 && mpend));
    if (mq.size() != 0) begin
      chk("head",      issue_instr,        64'(mq[0].p));
      chk("head_ctrl", issue_is_ctrl_flow, 64'(mq[0].c));
    end
    if (rst || flush) begin
      mq.delete();
      mpend = 1'b0;
    end else begin
      m_pop  = m_valid && issue_instr_ack;
      m_push = decoded_instr_valid && (mq.size() < DEPTH);
      if (m_pop) begin
        m_e = mq.pop_front();
        if (m_e.c)               mpend = 1'b1;
        else if (resolve_branch) mpend = 1'b0;
      end else if (resolve_branch) begin
        mpend = 1'b0;
      end
      if (m_push) begin
        m_e.p = decoded_instr;
        m_e.c = is_ctrl_flow;
        mq.push_back(m_e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic c, input logic [31:0] pc);
    decoded_instr_valid = v;
    is_ctrl_flow        = c;
    decoded_instr.pc    = pc;
    decoded_instr.op    = 8'($urandom);
    decoded_instr.rd    = 5'($urandom);
  endtask

  logic [31:0] hexp [5];

  initial begin
    rst = 1'b1; flush = 1'b0; issue_instr_ack = 1'b0; resolve_branch = 1'b0;
    offer(1'b0, 1'b0, 32'h0);
    tick(); tick();
    mid();
    chk("rst_ack", decoded_instr_ack, 64'd0);
    tick();
    rst = 1'b0;
    mid();
    chk("rst_count", count, 64'd0);
    chk("rst_valid", issue_instr_valid, 64'd0);
    chk("rst_ctrl",  issue_is_ctrl_flow, 64'd0);
    chk("rst_full",  full, 64'd0);
    chk("rst_stall", stall_ctrl_flow, 64'd0);
    chk("rst_ack1",  decoded_instr_ack, 64'd1);
    tick();

    // Fill to DEPTH, then drain in order while E waits for space.
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 1'b0, 32'hA0 + 32'(i));
      tick();
    end
    offer(1'b1, 1'b0, 32'hE4);
    mid();
    chk("fill_count", count, 64'd4);
    chk("fill_full",  full, 64'd1);
    chk("fill_ack_e", decoded_instr_ack, 64'd0);
    tick();
    issue_instr_ack = 1'b1;
    hexp = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hE4};
    for (int k = 0; k < 5; k++) begin
      mid();
      chk("drain_valid", issue_instr_valid, 64'd1);
      chk("drain_pc",    issue_instr.pc, 64'(hexp[k]));
      if (k == 0) chk("drain_count0", count, 64'd4);
      tick();
      if (k == 1) decoded_instr_valid = 1'b0;
    end
    mid();
    chk("drain_empty", count, 64'd0);
    tick();

    // Streaming: one push and one pop every cycle.
    for (int i = 0; i < 10; i++) begin
      offer(1'b1, 1'b0, 32'h500 + 32'(i));
      mid();
      if (i > 0) begin
        chk("stream_count", count, 64'd1);
        chk("stream_pc",    issue_instr.pc, 64'(32'h500 + 32'(i - 1)));
      end
      tick();
    end
    decoded_instr_valid = 1'b0;
    tick();
    issue_instr_ack = 1'b0;

    // Branch gating with a resolve pulse three cycles after the pop.
    offer(1'b1, 1'b1, 32'hB0); tick();
    offer(1'b1, 1'b0, 32'hB1); tick();
    offer(1'b1, 1'b0, 32'hB2); tick();
    decoded_instr_valid = 1'b0;
    issue_instr_ack = 1'b1;
    mid();
    chk("br_head_valid", issue_instr_valid, 64'd1);
    chk("br_head_ctrl",  issue_is_ctrl_flow, 64'd1);
    tick();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) resolve_branch = 1'b1;
      mid();
      chk("br_gated", issue_instr_valid, 64'd0);
      chk("br_stall", stall_ctrl_flow, 64'd1);
      tick();
    end
    resolve_branch = 1'b0;
    mid();
    chk("br_x_valid", issue_instr_valid, 64'd1);
    chk("br_x_pc",    issue_instr.pc, 64'h0B1);
    tick(); tick();
    issue_instr_ack = 1'b0;
    tick();

    // Resolve in the same cycle as a ctrl-flow pop: the pending state must survive.
    offer(1'b1, 1'b1, 32'hC0); tick();
    offer(1'b1, 1'b0, 32'hC1); tick();
    decoded_instr_valid = 1'b0;
    issue_instr_ack = 1'b1;
    resolve_branch = 1'b1;
    mid();
    chk("col_head", issue_instr.pc, 64'h0C0);
    tick();
    resolve_branch = 1'b0;
    mid();
    chk("col_gated", issue_instr_valid, 64'd0);
    chk("col_stall", stall_ctrl_flow, 64'd1);
    tick();
    resolve_branch = 1'b1;
    mid();
    chk("col_still_gated", issue_instr_valid, 64'd0);
    tick();
    resolve_branch = 1'b0;
    mid();
    chk("col_release", issue_instr_valid, 64'd1);
    chk("col_pc",      issue_instr.pc, 64'h0C1);
    tick();
    issue_instr_ack = 1'b0;

    // Flush while full, branch pending, and a push offered.
    offer(1'b1, 1'b1, 32'hF0); tick();
    decoded_instr_valid = 1'b0;
    issue_instr_ack = 1'b1;
    tick();
    issue_instr_ack = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      offer(1'b1, 1'b0, 32'hF0 + 32'(i));
      tick();
    end
    flush = 1'b1;
    offer(1'b1, 1'b0, 32'hFF);
    mid();
    chk("fl_full",  full, 64'd1);
    chk("fl_stall", stall_ctrl_flow, 64'd1);
    chk("fl_ack",   decoded_instr_ack, 64'd0);
    tick();
    flush = 1'b0;
    decoded_instr_valid = 1'b0;
    issue_instr_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("fl_count", count, 64'd0);
      chk("fl_valid", issue_instr_valid, 64'd0);
      chk("fl_stall0", stall_ctrl_flow, 64'd0);
      tick();
    end
    issue_instr_ack = 1'b0;

    // Reset mid-stream with two entries and a pending branch.
    offer(1'b1, 1'b1, 32'hD0); tick();
    decoded_instr_valid = 1'b0;
    issue_instr_ack = 1'b1;
    tick();
    issue_instr_ack = 1'b0;
    offer(1'b1, 1'b0, 32'hD1); tick();
    offer(1'b1, 1'b0, 32'hD2); tick();
    decoded_instr_valid = 1'b0;
    mid();
    chk("mr_count", count, 64'd2);
    chk("mr_stall", stall_ctrl_flow, 64'd1);
    tick();
    rst = 1'b1;
    mid();
    chk("mr_ack_rst", decoded_instr_ack, 64'd0);
    tick();
    rst = 1'b0;
    mid();
    chk("mr_count0", count, 64'd0);
    chk("mr_valid0", issue_instr_valid, 64'd0);
    chk("mr_ctrl0",  issue_is_ctrl_flow, 64'd0);
    chk("mr_stall0", stall_ctrl_flow, 64'd0);
    chk("mr_full0",  full, 64'd0);
    chk("mr_ack1",   decoded_instr_ack, 64'd1);
    tick();
    offer(1'b1, 1'b0, 32'hD9);
    tick();
    decoded_instr_valid = 1'b0;
    mid();
    chk("mr_push_valid", issue_instr_valid, 64'd1);
    chk("mr_push_pc",    issue_instr.pc, 64'h0D9);
    tick();

    // Randomized traffic; the model process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      offer($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 20, $urandom);
      issue_instr_ack = $urandom_range(0, 99) < 60;
      resolve_branch  = $urandom_range(0, 99) < 15;
      flush           = $urandom_range(0, 199) < 3;
      rst             = $urandom_range(0, 299) < 2;
      tick();
    end
    rst = 1'b0; flush = 1'b0; decoded_instr_valid = 1'b0;
    issue_instr_ack = 1'b0; resolve_branch = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_issue_fifo.md
# decode_issue_fifo

Registered FIFO between the decode stage and the issue stage. It buffers decoded `scoreboard_entry_t` instructions so that a stalled issue stage does not back-pressure decode on the same cycle. It also enforces single-outstanding control flow: after a control-flow instruction leaves the FIFO, nothing more is presented to issue until the branch is resolved. Its consumer is the issue stage's `decoded_instr_i` / `decoded_instr_valid_i` / `is_ctrl_flow_i` / `decoded_instr_ack_o` port group.

## Interface

**Parameters**
- `DEPTH`, default 4: number of entries; must be a power of two and ≥ 2.

**Ports**
- `clk_i`, input, 1: clock. Single clock domain.
- `rst_i`, input, 1: reset, synchronous, active-high.
- `flush_i`, input, 1: discard all buffered entries and the pending-branch state.
- `decoded_instr_i`, input, `scoreboard_entry_t`: decoded instruction from decode.
- `decoded_instr_valid_i`, input, 1: decode offers an entry.
- `is_ctrl_flow_i`, input, 1: the offered entry is a branch or jump.
- `decoded_instr_ack_o`, output, 1: FIFO accepts the offered entry this cycle.
- `issue_instr_o`, output, `scoreboard_entry_t`: head entry, sent to issue.
- `issue_instr_valid_o`, output, 1: head entry is presented to issue.
- `issue_is_ctrl_flow_o`, output, 1: head entry is control flow.
- `issue_instr_ack_i`, input, 1: issue consumed the head entry.
- `resolve_branch_i`, input, 1: execute resolved the outstanding control-flow instruction.
- `count_o`, output, `$clog2(DEPTH+1)`: number of occupied entries.
- `full_o`, output, 1: `count_o == DEPTH`.
- `stall_ctrl_flow_o`, output, 1: entries are present but held back by an unresolved branch (performance counter).

## Operation

**Storage**
- Circular buffer of `DEPTH` entries. Each entry holds a payload plus a ctrl-flow bit.
- Read pointer and write pointer are each `$clog2(DEPTH)` bits and wrap naturally at `DEPTH-1 -> 0`.
- Count register holds `0..DEPTH`.

**Push**
- `decoded_instr_ack_o = !full && !flush_i && !rst_i`.
- A push occurs when `decoded_instr_valid_i && decoded_instr_ack_o`. The entry is written at the write pointer, and the write pointer increments.
- There is no push-when-full, even if a pop happens in the same cycle. This keeps the ack path free of the downstream ack.

**Head and pop**
- `issue_instr_valid_o = (count != 0) && !branch_pending_q`.
- `issue_instr_o` and `issue_is_ctrl_flow_o` always show the entry at the read pointer, even when valid is low.
- A pop occurs when `issue_instr_valid_o && issue_instr_ack_i`. The read pointer increments.
- Simultaneous push and pop leaves the count unchanged.

**Branch gating (`branch_pending_q`)**
- Set on a pop whose ctrl-flow bit is 1.
- Cleared by `resolve_branch_i`.
- If set and clear occur in the same cycle, set wins.
- `resolve_branch_i` while the bit is 0 and no ctrl-flow pop is happening is ignored.
- `stall_ctrl_flow_o = (count != 0) && branch_pending_q`.

**Flush and reset**
- Both clear the pointers, count and `branch_pending_q` to 0 on the next edge.
- Both suppress any push or pop in the same cycle.
- Payload storage is not cleared.

## Timing

- All state updates on the `clk_i` rising edge.
- Latency: an entry pushed at edge N is at the head and can be valid in the cycle after edge N. There is no combinational fall-through from input to output.
- Throughput: 1 push and 1 pop per cycle sustained while not full and no ctrl-flow gating is active.
- A ctrl-flow entry popped at edge N forces `issue_instr_valid_o = 0` from edge N.
- If `resolve_branch_i` is high in cycle M, the next entry can be valid in the cycle after edge M.
- Reset values of outputs:
  - `decoded_instr_ack_o = 0` while `rst_i` is high, 1 afterwards.
  - `issue_instr_valid_o = 0`, `issue_is_ctrl_flow_o = 0`.
  - `count_o = 0`, `full_o = 0`, `stall_ctrl_flow_o = 0`.
  - `issue_instr_o` is don't-care (storage uninitialised; X-tolerant).
- Mid-operation reset or flush discards all entries, including one being acked in that cycle; upstream must not treat it as accepted because ack was low.
- Outputs depend only on registered state, except `decoded_instr_ack_o`, which depends combinationally on `flush_i` and `rst_i`.

## Test plan

- **Fill/drain, `DEPTH=4`:** push entries A–E with `issue_instr_ack_i = 0`.
  - Required: A–D accepted; `full_o = 1` and `decoded_instr_ack_o = 0` on E.
  - Then ack continuously. Required: A, B, C, D appear in order on consecutive cycles; `count_o` goes 4 → 0; E is accepted once ack rises.
- **Streaming:** push and pop every cycle for 10 cycles.
  - Required: `count_o` stays at 1 after the first cycle; output sequence equals input sequence; pointers wrap twice without loss.
- **Branch gating:** push a branch B (ctrl=1) followed by X and Y, then ack continuously.
  - Required: B pops; `issue_instr_valid_o = 0` and `stall_ctrl_flow_o = 1` until `resolve_branch_i` pulses 3 cycles later; X becomes valid the cycle after the pulse.
- **Set/clear collision:** hold `resolve_branch_i = 1` in the same cycle a ctrl-flow entry pops.
  - Required: `branch_pending_q` remains set; the next entry stays gated until a later resolve pulse.
- **Flush with full FIFO, pending branch and a simultaneous push:**
  - Required: next cycle `count_o = 0`, `issue_instr_valid_o = 0`, `stall_ctrl_flow_o = 0`; the pushed entry never appears.
- **Reset mid-stream with 2 entries and pending branch set:** assert `rst_i` for 1 cycle.
  - Required: all outputs return to their reset values; the first push after reset appears as valid one cycle later.
